// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM skid stage: occupancy states,
// default control-bundle width, the bubble control value and the
// bit offsets of the fields inside the control bundle.
package exmem_pkg;

    // Occupancy of the two-entry stage
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } exmem_state_t;

    localparam int EXMEM_NB_CTRL = 14;

    // Bubble: every enable bit cleared, access width field parked at 2'b11
    localparam logic [EXMEM_NB_CTRL-1:0] EXMEM_RST_CTRL = 14'b0000_0000_1100_00;

    // Control-bundle field offsets (LSB positions); bits 13:12 are spare
    localparam int CTRL_ALUOP_LSB = 0;   // 4 bits
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_WIDTH_LSB = 4;   // 2 bits
    localparam int CTRL_WIDTH_W   = 2;
    localparam int CTRL_SIGN      = 6;
    localparam int CTRL_ALUSRC    = 7;
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMWRITE  = 9;
    localparam int CTRL_MEMREAD   = 10;
    localparam int CTRL_MEM2REG   = 11;

endpackage

// File: rtl/exmem_entry.sv
// One payload register of the EX/MEM stage (control, result, store data,
// destination register). Clear reloads the bubble value; load captures.
module exmem_entry
    import exmem_pkg::*;
#(
    parameter int                NB_DATA  = 32,
    parameter int                NB_REG   = 5,
    parameter int                NB_CTRL  = EXMEM_NB_CTRL,
    parameter logic [NB_CTRL-1:0] RST_CTRL = EXMEM_RST_CTRL
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_data4mem,
    output logic [NB_REG-1:0]  o_write_reg
);

    logic [NB_CTRL-1:0] ctrl_reg;
    logic [NB_DATA-1:0] result_reg;
    logic [NB_DATA-1:0] data4mem_reg;
    logic [NB_REG-1:0]  write_reg_reg;

    // Payload storage: clear wins over load so a flush always leaves a bubble
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            ctrl_reg      <= RST_CTRL;
            result_reg    <= '0;
            data4mem_reg  <= '0;
            write_reg_reg <= '0;
        end else if (i_clear) begin
            ctrl_reg      <= RST_CTRL;
            result_reg    <= '0;
            data4mem_reg  <= '0;
            write_reg_reg <= '0;
        end else if (i_load) begin
            ctrl_reg      <= i_ctrl;
            result_reg    <= i_result;
            data4mem_reg  <= i_data4mem;
            write_reg_reg <= i_write_reg;
        end
    end

    assign o_ctrl      = ctrl_reg;
    assign o_result    = result_reg;
    assign o_data4mem  = data4mem_reg;
    assign o_write_reg = write_reg_reg;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage with valid/ready handshake and a two-entry skid
// buffer. The main entry drives the outputs; the skid entry catches the
// one extra entry accepted while downstream stalls. Handshake outputs come
// only from registered state and i_halt, breaking the ready path.
module exmem_skid_stage
    import exmem_pkg::*;
#(
    parameter int                NB_DATA  = 32,
    parameter int                NB_REG   = 5,
    parameter int                NB_CTRL  = EXMEM_NB_CTRL,
    parameter logic [NB_CTRL-1:0] RST_CTRL = EXMEM_RST_CTRL,
    parameter int                NB_CNT   = 16
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4mem,
    input  logic               i_regdst,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_REG-1:0]  i_rt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_data4mem,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_CNT-1:0]  o_stall_cnt
);

    exmem_state_t       state_reg;
    exmem_state_t       state_next;
    logic               up_xfer;
    logic               down_xfer;
    logic               main_load;
    logic               skid_load;
    logic [NB_REG-1:0]  in_write_reg;
    logic [NB_CNT-1:0]  stall_cnt_reg;

    // Main-load source mux: skid contents when draining FULL, else input
    logic [NB_CTRL-1:0] main_ctrl_d;
    logic [NB_DATA-1:0] main_result_d;
    logic [NB_DATA-1:0] main_data4mem_d;
    logic [NB_REG-1:0]  main_write_reg_d;

    logic [NB_CTRL-1:0] skid_ctrl;
    logic [NB_DATA-1:0] skid_result;
    logic [NB_DATA-1:0] skid_data4mem;
    logic [NB_REG-1:0]  skid_write_reg;

    assign o_ready   = !i_halt && (state_reg != ST_FULL);
    assign o_valid   = !i_halt && (state_reg != ST_EMPTY);
    assign up_xfer   = i_valid && o_ready;
    assign down_xfer = o_valid && i_ready;

    // Destination is resolved once, at capture, and travels with the entry
    assign in_write_reg = i_regdst ? i_rt : i_rd;

    assign main_ctrl_d      = (state_reg == ST_FULL) ? skid_ctrl      : i_ctrl;
    assign main_result_d    = (state_reg == ST_FULL) ? skid_result    : i_result;
    assign main_data4mem_d  = (state_reg == ST_FULL) ? skid_data4mem  : i_data4mem;
    assign main_write_reg_d = (state_reg == ST_FULL) ? skid_write_reg : in_write_reg;

    // Next-state and entry-load decode; flush overrides, halt freezes everything
    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        if (i_flush) begin
            state_next = ST_EMPTY;
        end else if (!i_halt) begin
            case (state_reg)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && down_xfer) begin
                        main_load = 1'b1;
                    end else if (up_xfer) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (down_xfer) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (down_xfer) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Saturating count of cycles the head entry waited on downstream
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_reg <= '0;
        end else if (o_valid && !i_ready && (stall_cnt_reg != {NB_CNT{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;

    exmem_entry #(
        .NB_DATA  (NB_DATA),
        .NB_REG   (NB_REG),
        .NB_CTRL  (NB_CTRL),
        .RST_CTRL (RST_CTRL)
    ) u_main (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_clear     (i_flush),
        .i_load      (main_load),
        .i_ctrl      (main_ctrl_d),
        .i_result    (main_result_d),
        .i_data4mem  (main_data4mem_d),
        .i_write_reg (main_write_reg_d),
        .o_ctrl      (o_ctrl),
        .o_result    (o_result),
        .o_data4mem  (o_data4mem),
        .o_write_reg (o_write_reg)
    );

    exmem_entry #(
        .NB_DATA  (NB_DATA),
        .NB_REG   (NB_REG),
        .NB_CTRL  (NB_CTRL),
        .RST_CTRL (RST_CTRL)
    ) u_skid (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_clear     (i_flush),
        .i_load      (skid_load),
        .i_ctrl      (i_ctrl),
        .i_result    (i_result),
        .i_data4mem  (i_data4mem),
        .i_write_reg (in_write_reg),
        .o_ctrl      (skid_ctrl),
        .o_result    (skid_result),
        .o_data4mem  (skid_data4mem),
        .o_write_reg (skid_write_reg)
    );

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: directed scenarios plus randomized traffic,
// checked each cycle against a queue-based model of the stage.
module tb_exmem_skid_stage;

    localparam logic [13:0] BUBBLE = 14'b0000_0000_1100_00;

    typedef struct {
        logic [13:0] ctrl;
        logic [31:0] result;
        logic [31:0] data;
        logic [4:0]  wr;
    } ent_t;

    logic        clk = 1'b0;
    logic        i_reset, i_halt, i_flush, i_valid, i_ready, i_regdst;
    logic [13:0] i_ctrl;
    logic [31:0] i_result, i_data4mem;
    logic [4:0]  i_rd, i_rt;

    logic        o_ready, o_valid;
    logic [13:0] o_ctrl;
    logic [31:0] o_result, o_data4mem;
    logic [4:0]  o_write_reg;
    logic [15:0] o_stall_cnt;

    logic        s_ready, s_valid;
    logic [13:0] s_ctrl;
    logic [31:0] s_result, s_data4mem;
    logic [4:0]  s_write_reg;
    logic [1:0]  s_stall_cnt;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    ent_t shown;
    int   stall;

    always #5 clk = ~clk;

    exmem_skid_stage dut (
        .clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl),
        .i_result(i_result), .i_data4mem(i_data4mem), .i_regdst(i_regdst),
        .i_rd(i_rd), .i_rt(i_rt), .o_valid(o_valid), .i_ready(i_ready),
        .o_ctrl(o_ctrl), .o_result(o_result), .o_data4mem(o_data4mem),
        .o_write_reg(o_write_reg), .o_stall_cnt(o_stall_cnt)
    );

    exmem_skid_stage #(.NB_CNT(2)) dut_sat (
        .clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(s_ready), .i_ctrl(i_ctrl),
        .i_result(i_result), .i_data4mem(i_data4mem), .i_regdst(i_regdst),
        .i_rd(i_rd), .i_rt(i_rt), .o_valid(s_valid), .i_ready(i_ready),
        .o_ctrl(s_ctrl), .o_result(s_result), .o_data4mem(s_data4mem),
        .o_write_reg(s_write_reg), .o_stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t bubble_ent();
        ent_t e;
        e.ctrl = BUBBLE; e.result = '0; e.data = '0; e.wr = '0;
        return e;
    endfunction

    // Compare every DUT output with what the model predicts for this cycle
    task automatic check_outputs(input logic exp_ready, input logic exp_valid);
        ent_t h;
        h = (q.size() > 0) ? q[0] : shown;
        check("ready", o_ready, exp_ready);
        check("valid", o_valid, exp_valid);
        check("ctrl", o_ctrl, h.ctrl);
        check("result", o_result, h.result);
        check("data4mem", o_data4mem, h.data);
        check("write_reg", o_write_reg, h.wr);
        check("stall_cnt", o_stall_cnt, (stall > 65535) ? 65535 : stall);
        check("stall_sat", s_stall_cnt, (stall > 3) ? 3 : stall);
    endtask

    // One clock of traffic; returns whether the offered entry was taken
    task automatic cycle(input logic v, input logic r, input logic h, input logic f,
                         input logic [13:0] c, input logic [31:0] res,
                         input logic [31:0] dat, input logic rdst,
                         input logic [4:0] rd, input logic [4:0] rt,
                         output logic accepted);
        logic exp_ready, exp_valid, up, down;
        ent_t e, popped;
        i_valid = v; i_ready = r; i_halt = h; i_flush = f;
        i_ctrl = c; i_result = res; i_data4mem = dat;
        i_regdst = rdst; i_rd = rd; i_rt = rt;
        #1;
        exp_ready = !h && (q.size() < 2);
        exp_valid = !h && (q.size() > 0);
        check_outputs(exp_ready, exp_valid);
        up   = v && exp_ready;
        down = exp_valid && r;
        accepted = up && !f;
        $display("cyc v=%0b r=%0b h=%0b f=%0b res=%0h occ=%0d", v, r, h, f, res, q.size());
        @(posedge clk);
        if (exp_valid && !r) stall++;
        if (f) begin
            q.delete();
            shown = bubble_ent();
        end else begin
            if (down) begin
                popped = q.pop_front();
                shown = popped;
            end
            if (up) begin
                e.ctrl = c; e.result = res; e.data = dat; e.wr = rdst ? rt : rd;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic r, input logic h);
        logic a;
        cycle(1'b0, r, h, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, a);
    endtask

    task automatic push(input logic r, input logic [31:0] res, input logic rdst, output logic a);
        cycle(1'b1, r, 1'b0, 1'b0, 14'h0155 ^ res[13:0], res, ~res, rdst, 5'd3, 5'd7, a);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        #1;
        q.delete();
        shown = bubble_ent();
        stall = 0;
        check("rst_ready", o_ready, !i_halt);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ctrl", o_ctrl, BUBBLE);
        check("rst_wr", o_write_reg, 5'd0);
        check("rst_cnt", o_stall_cnt, 16'd0);
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    initial begin
        logic a;
        i_reset = 1'b1; i_halt = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_ctrl = '0; i_result = '0; i_data4mem = '0; i_regdst = 1'b0; i_rd = '0; i_rt = '0;
        shown = bubble_ent();
        stall = 0;
        @(negedge clk);
        do_reset();

        // Streaming with alternating destination select
        for (int i = 0; i < 4; i++) push(1'b1, 32'h100 + i, i[0], a);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Back-pressure: A, B absorbed, C held upstream until space appears
        push(1'b0, 32'hA, 1'b0, a);
        push(1'b0, 32'hB, 1'b1, a);
        push(1'b0, 32'hC, 1'b0, a);
        check("c_held", a, 1'b0);
        for (int k = 0; k < 10; k++) begin
            push(1'b1, 32'hC, 1'b0, a);
            if (a) break;
        end
        check("c_taken", a, 1'b1);
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b0);

        // Flush while FULL with a new entry offered
        push(1'b0, 32'h11, 1'b0, a);
        push(1'b0, 32'h22, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 32'h33, 32'h44, 1'b1, 5'd1, 5'd2, a);
        idle(1'b1, 1'b0);

        // Halt for 3 cycles holding one entry, then release
        push(1'b0, 32'h55, 1'b1, a);
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Long stall to saturate the narrow counter
        push(1'b0, 32'h66, 1'b0, a);
        for (int k = 0; k < 6; k++) idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);

        // Randomized traffic with occasional halt, flush and reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                      14'($urandom), $urandom, $urandom, 1'($urandom),
                      5'($urandom), 5'($urandom), a);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exmem_skid_stage.md
# exmem_skid_stage

Parametrised EX/MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer, replacing the fixed always-load stage register between execute and memory. It carries an opaque control bundle plus ALU result and store data, resolves the destination register at capture, supports bubble-inserting flush and a global halt, and counts downstream stall cycles for debug.

## Interface
- NB_DATA, 32, width of result and store-data paths
- NB_REG, 5, register-index width
- NB_CTRL, 14, width of opaque control bundle (mem2reg, memRead, memWrite, regWrite, aluSrc, width, sign, aluOP)
- RST_CTRL, 14'b0000_0000_1100_00, control value loaded on reset/flush (bubble; width field = 2'b11)
- NB_CNT, 16, stall counter width
- clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_halt  in  1  freeze stage
- i_flush  in  1  synchronous flush, discard all held and incoming entries
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept this cycle
- i_ctrl  in  NB_CTRL  control bundle
- i_result  in  NB_DATA  ALU result
- i_data4mem  in  NB_DATA  store data
- i_regdst  in  1  1: dest = rt, 0: dest = rd
- i_rd, i_rt  in  NB_REG  candidate destinations
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts
- o_ctrl  out  NB_CTRL; o_result, o_data4mem  out  NB_DATA; o_write_reg  out  NB_REG  head entry payload
- o_stall_cnt  out  NB_CNT  saturating count of stalled cycles

## Operation
- Two entries: main (drives outputs) and skid. States EMPTY (0), ONE (main valid), FULL (both valid).
- Upstream transfer: i_valid & o_ready. Downstream transfer: o_valid & i_ready.
- o_ready = !halt & state != FULL. o_valid = !halt & state != EMPTY.
- EMPTY: up -> main <= input, ONE.
- ONE: up & down -> main <= input, ONE; up & !down -> skid <= input, FULL; !up & down -> EMPTY; else hold.
- FULL: down -> main <= skid, ONE; else hold. No upstream accept.
- Destination resolved at capture: i_regdst ? i_rt : i_rd; stored with entry.
- Priority: reset > flush > halt > handshake.
- Flush: state -> EMPTY; main and skid ctrl <= RST_CTRL, data and write_reg <= 0; incoming entry that cycle discarded; applies even when halted.
- Halt: state, payload and counter frozen; o_valid = o_ready = 0 so no transfer occurs.
- o_stall_cnt increments each cycle with o_valid & !i_ready; saturates at all-ones; cleared only by reset.
- Payload outputs when EMPTY hold last values (RST_CTRL/0 after reset or flush); consumers qualify with o_valid.

## Timing
- Reset (async, i_reset low): state EMPTY, o_valid 0, o_ctrl RST_CTRL, o_result/o_data4mem/o_write_reg 0, o_stall_cnt 0; o_ready 1 once i_halt low.
- Latency 1 cycle: entry accepted at edge N visible on outputs after edge N.
- Throughput 1 entry/cycle with i_ready held high; no bubbles inserted by the stage.
- o_ready and o_valid depend only on registered state and i_halt; no combinational path from i_ready or i_valid.
- Back-pressure: with i_ready low, stage absorbs exactly 2 entries, then o_ready drops the cycle after FULL is reached.
- Reset release mid-stream: entries in flight are lost; upstream restarts after reset.

## Structure
- Package exmem_pkg: state encoding (EMPTY/ONE/FULL), default NB_CTRL, RST_CTRL, control-bundle field offsets.
- Sub-module exmem_entry: one payload register (ctrl, result, data4mem, write_reg) with load and clear, instantiated for main and skid.
- Top holds state machine, mux main-load source (input vs skid), stall counter.

## Test plan
- Reset with i_halt 0 -> o_valid 0, o_ready 1, o_ctrl RST_CTRL, o_write_reg 0, o_stall_cnt 0.
- Stream 4 entries, i_ready 1, i_regdst alternating with rd=3, rt=7 -> outputs one cycle later in order, o_write_reg 3,7,3,7, no gaps.
- i_ready 0, push results 0xA, 0xB, 0xC -> 0xA, 0xB held, o_ready low, 0xC held upstream; raise i_ready -> 0xA, 0xB, 0xC delivered in order; o_stall_cnt = stalled cycles.
- FULL state, assert i_flush with i_valid 1 -> next cycle o_valid 0, o_ctrl RST_CTRL, new entry dropped.
- i_halt 1 for 3 cycles in ONE with i_ready 1 -> no transfer, o_valid 0, counter unchanged; release -> held entry delivered.
- NB_CNT=2, hold stall 6 cycles -> o_stall_cnt saturates at 3.
